// File: rtl/logic_oracle_bridge.sv
// logic_oracle_bridge
//   Connects the CPU's single-outstanding logic-engine port to an external host
//   oracle. Requests go out over a valid/ready channel. Tagged responses come
//   back with no backpressure. A response is accepted only if its tag matches
//   the current request tag, so late replies to earlier requests are dropped.
//   Also provides a sticky error flag and a count of completed requests.
//
// Optional feature (macro ORACLE_TIMEOUT_EN):
//   When the macro is defined, WAIT is bounded to TIMEOUT_CYCLES cycles. On
//   expiry the bridge completes with TIMEOUT_DATA and sets err_flag.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   logic_req       CPU request, held high until logic_ack is seen
//   logic_addr      CPU query address, latched on acceptance
//   logic_ack       one-cycle completion pulse
//   logic_data      result, valid in the ack cycle and held afterwards
//   host_req_*      request channel to the host (valid/ready, addr, tag)
//   host_rsp_*      response channel from the host (valid, tag, data, err)
//   busy            high whenever the FSM is not idle
//   err_flag        sticky host-error / timeout indicator
//   req_count       completed requests, wraps modulo 2^32
module logic_oracle_bridge #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TAG_W          = 8,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(32'hDEAD0001)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              logic_req,
  input  logic [DATA_W-1:0] logic_addr,
  output logic              logic_ack,
  output logic [DATA_W-1:0] logic_data,
  output logic              host_req_valid,
  input  logic              host_req_ready,
  output logic [DATA_W-1:0] host_req_addr,
  output logic [TAG_W-1:0]  host_req_tag,
  input  logic              host_rsp_valid,
  input  logic [TAG_W-1:0]  host_rsp_tag,
  input  logic [DATA_W-1:0] host_rsp_data,
  input  logic              host_rsp_err,
  output logic              busy,
  output logic              err_flag,
  output logic [31:0]       req_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;
  logic   rsp_hit;
  logic   timeout_hit;

  // Only WAIT accepts responses. Anything arriving in ISSUE, including the
  // cycle in which the request handshake completes, is ignored.
  assign rsp_hit = (state == S_WAIT) && host_rsp_valid && (host_rsp_tag == host_req_tag);

`ifdef ORACLE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts the WAIT cycles already spent. It is held at zero outside WAIT,
  // so it restarts on every entry into WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A matching response in the final cycle takes priority over the timeout.
  assign timeout_hit = (state == S_WAIT) && !rsp_hit &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    host_req_valid = 1'b0;
    logic_ack      = 1'b0;
    busy           = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (logic_req) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        host_req_valid = 1'b1;
        if (host_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_hit || timeout_hit) state_nxt = S_ACK;
      end
      S_ACK: begin
        logic_ack = 1'b1;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Stay here until the CPU drops its request, so that a request
        // held high after completion is not served a second time.
        if (!logic_req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_req_addr <= '0;
      host_req_tag  <= '0;
      logic_data    <= '0;
      err_flag      <= 1'b0;
      req_count     <= '0;
    end else begin
      if ((state == S_IDLE) && logic_req) begin
        host_req_addr <= logic_addr;
      end
      if (rsp_hit) begin
        logic_data <= host_rsp_data;
        err_flag   <= err_flag | host_rsp_err;
      end else if (timeout_hit) begin
        logic_data <= TIMEOUT_DATA;
        err_flag   <= 1'b1;
      end
      // The tag advances even after a timeout, so a late reply to the
      // abandoned request no longer matches and is dropped as stale.
      if (state == S_ACK) begin
        req_count    <= req_count + 32'd1;
        host_req_tag <= host_req_tag + 1'b1;
      end
    end
  end

endmodule
